// File: rtl/aes_decrypt_iter.sv
// rtl/aes_decrypt_iter.sv - iterative AES-128 inverse cipher, one round per clock
// Purpose: takes a ciphertext block and the round-10 key, runs ten inverse
//   rounds while rolling the key schedule backwards, and returns plaintext.
//   Byte 0 is bits [127:120]; column 0 is bits [127:96].
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (ready only while idle)
//   ciphertext, key_last  input block and round-10 key, sampled on accept
//   out_valid/out_ready   output handshake
//   plaintext             registered result, held until taken
`timescale 1ns/1ps
module aes_decrypt_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] y;
    y = gf_inv(a);
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] y;
    y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Row r of column c takes the byte that sat r columns to its left.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++)
      o[127 - 8 * k -: 8] = inv_sbox(s[127 - 8 * k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic [1:0]   state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   rc_q, rc_d;
  logic [127:0] pt_q, pt_d;

  logic [31:0]  n0, n1, n2, n3;
  logic [3:0]   rcon_idx;
  logic [127:0] prev_key;
  logic [127:0] t;

  // Previous round key from the current one; rc+1 selects the Rcon that
  // produced the current key, so rc=0 applies Rcon[1].
  always_comb begin
    n3       = rk_q[31:0]  ^ rk_q[63:32];
    n2       = rk_q[63:32] ^ rk_q[95:64];
    n1       = rk_q[95:64] ^ rk_q[127:96];
    rcon_idx = rc_q + 4'd1;
    n0       = rk_q[127:96] ^ sub_word({n3[23:0], n3[31:24]}) ^ {rcon(rcon_idx), 24'h000000};
    prev_key = {n0, n1, n2, n3};
    t        = inv_sub_bytes(inv_shift_rows(st_q)) ^ prev_key;
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    rc_d    = rc_q;
    pt_d    = pt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d    = ciphertext ^ key_last;
          rk_d    = key_last;
          rc_d    = 4'd9;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        rk_d = prev_key;
        if (rc_q != 4'd0) begin
          st_d = inv_mix_columns(t);
          rc_d = rc_q - 4'd1;
        end else begin
          pt_d    = t;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      rc_q    <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      rc_q    <= rc_d;
      pt_q    <= pt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign plaintext = pt_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// tb/tb_aes_decrypt_iter.sv - self-checking bench for aes_decrypt_iter
`timescale 1ns/1ps
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  aes_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ciphertext(ciphertext),
    .key_last  (key_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plaintext (plaintext)
  );

  // Forward-cipher reference: table S-box, key expansion, encryption.
  logic [7:0]  sbox_t [0:255];
  logic [31:0] kw [0:43];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) kw[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = kw[i - 1];
      if (i % 4 == 0) begin
        tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      kw[i] = kw[i - 4] ^ tmp;
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [0:15];
    logic [7:0]   u [0:15];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[127 - 8 * k -: 8] ^ kw[k / 4][31 - 8 * (k % 4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) s[k] = sbox_t[s[k]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) u[4 * c + q] = s[4 * ((c + q) % 4) + q];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = xt(u[4*c]) ^ xt(u[4*c+1]) ^ u[4*c+1] ^ u[4*c+2] ^ u[4*c+3];
          s[4*c+1] = u[4*c] ^ xt(u[4*c+1]) ^ xt(u[4*c+2]) ^ u[4*c+2] ^ u[4*c+3];
          s[4*c+2] = u[4*c] ^ u[4*c+1] ^ xt(u[4*c+2]) ^ xt(u[4*c+3]) ^ u[4*c+3];
          s[4*c+3] = xt(u[4*c]) ^ u[4*c] ^ u[4*c+1] ^ u[4*c+2] ^ xt(u[4*c+3]);
        end else begin
          for (int q = 0; q < 4; q++) s[4*c+q] = u[4*c+q];
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ kw[4 * r + k / 4][31 - 8 * (k % 4) -: 8];
    end
    o = '0;
    for (int k = 0; k < 16; k++) o[127 - 8 * k -: 8] = s[k];
    return o;
  endfunction

  // Drives one block from idle through handshake; out_ready stalls for
  // 'stall' cycles after out_valid. ok=0 if any bounded wait expired.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] key, input int stall,
                           output logic [127:0] pt, output int lat, output bit ok);
    int guard;
    ok = 1'b1;
    lat = 0;
    guard = 0;
    ciphertext = ct;
    key_last   = key;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) ok = 1'b0;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
    key_last   = {$urandom(), $urandom(), $urandom(), $urandom()};
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) ok = 1'b0;
    repeat (stall) begin
      @(posedge clk); #1;
    end
    pt = plaintext;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    ciphertext = '0;
    key_last = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (plaintext !== 128'h0) begin n_fail++; $display("FAIL reset_plaintext: got %h expected 0", plaintext); end
    n_checks++; if (dut.rk_q !== 128'h0) begin n_fail++; $display("FAIL reset_rk: got %h expected 0", dut.rk_q); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
  endtask

  task automatic test_fips_c1();
    int lat;
    ciphertext = C1_CT;
    key_last = C1_KEY;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ciphertext = '0;
    key_last = '0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL c1_in_ready_after_accept: got %b expected 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL c1_latency: got %0d expected 10", lat); end
    n_checks++; if (plaintext !== C1_PT) begin n_fail++; $display("FAIL c1_plaintext: got %h expected %h", plaintext, C1_PT); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL c1_in_ready_done: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL c1_return_idle: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_app_b();
    logic [127:0] pt;
    int lat;
    bit ok;
    run_block(B_CT, B_KEY, 2, pt, lat, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL appb_timeout: got ok=%b expected 1", ok); end
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL appb_latency: got %0d expected 10", lat); end
    n_checks++; if (pt !== B_PT) begin n_fail++; $display("FAIL appb_plaintext: got %h expected %h", pt, B_PT); end
    n_checks++; if (dut.rk_q !== B_CK) begin n_fail++; $display("FAIL appb_cipher_key: got %h expected %h", dut.rk_q, B_CK); end
  endtask

  task automatic test_backpressure();
    int guard;
    ciphertext = C1_CT;
    key_last = C1_KEY;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_reach_done: got out_valid=%b expected 1", out_valid); end
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      ciphertext = {$urandom(), $urandom(), $urandom(), $urandom()};
      key_last = B_KEY;
      @(posedge clk); #1;
      n_checks++; if (plaintext !== C1_PT) begin n_fail++; $display("FAIL bp_plaintext_stable[%0d]: got %h expected %h", i, plaintext, C1_PT); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid_held[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low[%0d]: got %b expected 0", i, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_no_ghost_accept: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int cyc, acc_n, out_n;
    int acc_cyc [0:1];
    logic [127:0] got [0:1];
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    got[0] = '0; got[1] = '0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    ciphertext = C1_CT;
    key_last = C1_KEY;
    cyc = 0; acc_n = 0; out_n = 0;
    while (out_n < 2 && cyc < 80) begin
      if (in_ready && in_valid) begin
        if (acc_n < 2) acc_cyc[acc_n] = cyc;
        acc_n++;
      end
      if (out_valid && out_ready) begin
        if (out_n < 2) got[out_n] = plaintext;
        out_n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc_n == 1) begin
        ciphertext = B_CT;
        key_last = B_KEY;
      end else if (acc_n >= 2) begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (acc_n !== 2 || out_n !== 2) begin n_fail++; $display("FAIL b2b_counts: got accepts=%0d outputs=%0d expected 2/2", acc_n, out_n); end
    n_checks++; if (acc_cyc[1] - acc_cyc[0] !== 12) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 12", acc_cyc[1] - acc_cyc[0]); end
    n_checks++; if (got[0] !== C1_PT) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", got[0], C1_PT); end
    n_checks++; if (got[1] !== B_PT) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", got[1], B_PT); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] pt;
    int lat;
    bit ok;
    ciphertext = C1_CT;
    key_last = C1_KEY;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (plaintext !== 128'h0) begin n_fail++; $display("FAIL rm_plaintext: got %h expected 0", plaintext); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (dut.rk_q !== 128'h0) begin n_fail++; $display("FAIL rm_rk: got %h expected 0", dut.rk_q); end
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_residue: got out_valid=%b expected 0", out_valid); end
    run_block(B_CT, B_KEY, 1, pt, lat, ok);
    n_checks++; if (ok !== 1'b1 || lat !== 10) begin n_fail++; $display("FAIL rm_fresh_block: got ok=%b lat=%0d expected 1/10", ok, lat); end
    n_checks++; if (pt !== B_PT) begin n_fail++; $display("FAIL rm_fresh_plaintext: got %h expected %h", pt, B_PT); end
  endtask

  task automatic test_random();
    logic [127:0] key, pt_exp, ct, kl, pt;
    int lat;
    bit ok;
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt_exp = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand_key(key);
      ct = encrypt(pt_exp);
      kl = {kw[40], kw[41], kw[42], kw[43]};
      run_block(ct, kl, int'($urandom_range(0, 3)), pt, lat, ok);
      n_checks++; if (ok !== 1'b1 || lat !== 10) begin n_fail++; $display("FAIL rand_timing[%0d]: got ok=%b lat=%0d expected 1/10", n, ok, lat); end
      n_checks++; if (pt !== pt_exp) begin n_fail++; $display("FAIL rand_plaintext[%0d]: got %h expected %h", n, pt, pt_exp); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    test_reset();
    test_fips_c1();
    test_app_b();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
